// File: rtl/cmm_hst_regbank_pkg.sv
// cmm_hst_regbank_pkg: register offsets, CTRL bit indices and decode helpers for the host register bank
package cmm_hst_regbank_pkg;
   localparam logic [7:0] OFS_ID       = 8'h00;
   localparam logic [7:0] OFS_CTRL     = 8'h04;
   localparam logic [7:0] OFS_SCRATCH  = 8'h08;
   localparam logic [7:0] OFS_INT_STAT = 8'h0C;
   localparam logic [7:0] OFS_INT_MASK = 8'h10;
   localparam logic [7:0] OFS_CNT_LO   = 8'h14;
   localparam logic [7:0] OFS_CNT_HI   = 8'h18;
   localparam int CTRL_CNT_EN  = 0;
   localparam int CTRL_CNT_CLR = 1;
   localparam int NUM_INT      = 8;
   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction
   function automatic logic ofs_valid(input logic [7:0] ofs);
      return ofs inside {OFS_ID, OFS_CTRL, OFS_SCRATCH, OFS_INT_STAT, OFS_INT_MASK, OFS_CNT_LO, OFS_CNT_HI};
   endfunction
endpackage

// File: rtl/cmm_hst_w1c_reg.sv
// cmm_hst_w1c_reg: W1C status register with hardware set, byte-strobed clear and set priority
module cmm_hst_w1c_reg #(
   parameter int W = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [W-1:0]           set_i,
   input  logic                   clr_en_i,
   input  logic [W-1:0]           clr_i,
   input  logic [(W+7)/8-1:0]     be_i,
   output logic [W-1:0]           q_o
);
   logic [W-1:0] q_q, q_d, clr_m;
   // clear only bits written with 1 in an enabled byte lane; a concurrent set wins
   always_comb begin
      clr_m = '0;
      for (int i = 0; i < W; i++) clr_m[i] = clr_en_i & clr_i[i] & be_i[i/8];
      q_d = set_i | (q_q & ~clr_m);
   end
   // status state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end
   assign q_o = q_q;
endmodule

// File: rtl/cmm_hst_regbank.sv
// cmm_hst_regbank: host register bank with ID, control, scratch, 64-bit counter snapshot and W1C interrupts
module cmm_hst_regbank
   import cmm_hst_regbank_pkg::*;
#(
   parameter int              C_AW   = 32,
   parameter logic [C_AW-1:0] C_BASE = '0,
   parameter logic [31:0]     C_ID   = 32'h5654_0100
) (
   input  logic            apb_pclk,
   input  logic            apb_preset,
   input  logic [3:0]      hst_sel,
   input  logic [C_AW-1:0] hst_addr,
   input  logic            hst_wen,
   input  logic [31:0]     hst_wdat,
   output logic            hst_rack,
   output logic [31:0]     hst_rdat,
   input  logic [6:0]      hw_evt,
   output logic            irq
);
   logic [7:0]         ofs;
   logic               hit, wr, rd, cnt_clr, wrap;
   logic [31:0]        bm, rd_val;
   logic               cnt_en_q, cnt_en_d;
   logic [31:0]        scratch_q, scratch_d, shadow_q, shadow_d;
   logic [NUM_INT-1:0] mask_q, mask_d, stat;
   logic [63:0]        cnt_q, cnt_d;
   logic               irq_q;

   assign ofs      = hst_addr[7:0];
   assign hit      = !apb_preset && hst_sel != 4'h0 && hst_addr[C_AW-1:8] == C_BASE[C_AW-1:8]
                     && hst_addr[1:0] == 2'b00 && ofs_valid(ofs);
   assign wr       = hit & hst_wen;
   assign rd       = hit & ~hst_wen;
   assign bm       = byte_mask(hst_sel);
   assign cnt_clr  = wr && ofs == OFS_CTRL && hst_sel[0] && hst_wdat[CTRL_CNT_CLR];
   assign wrap     = cnt_en_q & ~cnt_clr & (cnt_q[31:0] == 32'hFFFF_FFFF);
   assign hst_rack = hit;
   assign hst_rdat = rd ? rd_val : 32'h0;
   assign irq      = irq_q;

   // read mux; cnt_clr is a pulse and never stored, so CTRL reads back only cnt_en
   always_comb begin
      rd_val = 32'h0;
      case (ofs)
         OFS_ID:       rd_val = C_ID;
         OFS_CTRL:     rd_val = {31'h0, cnt_en_q};
         OFS_SCRATCH:  rd_val = scratch_q;
         OFS_INT_STAT: rd_val = {24'h0, stat};
         OFS_INT_MASK: rd_val = {24'h0, mask_q};
         OFS_CNT_LO:   rd_val = cnt_q[31:0];
         OFS_CNT_HI:   rd_val = shadow_q;
         default:      rd_val = 32'h0;
      endcase
   end

   // next-state for RW registers, counter and the hi-word shadow taken on a CNT_LO read
   always_comb begin
      cnt_en_d  = (wr && ofs == OFS_CTRL && hst_sel[0]) ? hst_wdat[CTRL_CNT_EN] : cnt_en_q;
      scratch_d = (wr && ofs == OFS_SCRATCH) ? (scratch_q & ~bm) | (hst_wdat & bm) : scratch_q;
      mask_d    = (wr && ofs == OFS_INT_MASK && hst_sel[0]) ? hst_wdat[NUM_INT-1:0] : mask_q;
      cnt_d     = cnt_clr ? 64'h0 : cnt_en_q ? cnt_q + 64'd1 : cnt_q;
      shadow_d  = (rd && ofs == OFS_CNT_LO) ? cnt_q[63:32] : shadow_q;
   end

   // register state and interrupt output
   always_ff @(posedge apb_pclk or posedge apb_preset) begin
      if (apb_preset) begin
         cnt_en_q  <= 1'b0;
         scratch_q <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         cnt_en_q  <= cnt_en_d;
         scratch_q <= scratch_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         irq_q     <= |(stat & mask_q);
      end
   end

   cmm_hst_w1c_reg #(.W(NUM_INT)) u_int_stat (
      .clk_i    (apb_pclk),
      .rst_i    (apb_preset),
      .set_i    ({wrap, hw_evt}),
      .clr_en_i (wr && ofs == OFS_INT_STAT),
      .clr_i    (hst_wdat[NUM_INT-1:0]),
      .be_i     (hst_sel[0]),
      .q_o      (stat)
   );
endmodule

// File: tb/tb_cmm_hst_regbank.sv
// tb_cmm_hst_regbank: directed self-checking bench for the host register bank
module tb_cmm_hst_regbank;
   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  sel = 4'h0;
   logic [31:0] addr = 32'h0, wdat = 32'h0;
   logic        wen = 1'b0;
   logic        rack, irq;
   logic [31:0] rdat;
   logic [6:0]  evt = 7'h0;
   int          n_chk = 0, n_fail = 0;

   cmm_hst_regbank dut (
      .apb_pclk   (clk),
      .apb_preset (rst),
      .hst_sel    (sel),
      .hst_addr   (addr),
      .hst_wen    (wen),
      .hst_wdat   (wdat),
      .hst_rack   (rack),
      .hst_rdat   (rdat),
      .hw_evt     (evt),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      sel = s; addr = a; wdat = d; wen = 1'b1;
      @(posedge clk);
      #1 sel = 4'h0; wen = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic ack, input logic [31:0] exp);
      @(negedge clk);
      sel = 4'hF; addr = a; wen = 1'b0;
      #1 chk({tag, ".rack"}, {31'h0, rack}, {31'h0, ack});
      chk({tag, ".rdat"}, rdat, exp);
      @(posedge clk);
      #1 sel = 4'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rd("id", 32'h00, 1'b1, 32'h5654_0100);
      rd("ctrl0", 32'h04, 1'b1, 32'h0);
      rd("scr0", 32'h08, 1'b1, 32'h0);
      rd("stat0", 32'h0C, 1'b1, 32'h0);
      rd("mask0", 32'h10, 1'b1, 32'h0);
      rd("hi0", 32'h18, 1'b1, 32'h0);
      wr(32'h08, 32'hAABB_CCDD, 4'b0101);
      rd("scr_be", 32'h08, 1'b1, 32'h00BB_00DD);
      wr(32'h08, 32'h1122_3344, 4'b1000);
      rd("scr_be2", 32'h08, 1'b1, 32'h11BB_00DD);
      rd("miss1c", 32'h1C, 1'b0, 32'h0);
      rd("miss09", 32'h09, 1'b0, 32'h0);
      rd("missbase", 32'h100, 1'b0, 32'h0);
      // counter snapshot across a low-word wrap
      wr(32'h04, 32'h1, 4'hF);
      @(negedge clk);
      force dut.cnt_q = 64'h0000_0001_FFFF_FFFE;
      #1 release dut.cnt_q;
      rd("cnt_lo", 32'h14, 1'b1, 32'hFFFF_FFFF);
      rd("cnt_hi", 32'h18, 1'b1, 32'h1);
      rd("wrap_stat", 32'h0C, 1'b1, 32'h80);
      // clear while counting
      wr(32'h04, 32'h3, 4'hF);
      rd("clr_lo", 32'h14, 1'b1, 32'h0);
      rd("clr_ctrl", 32'h04, 1'b1, 32'h1);
      rd("clr_lo2", 32'h14, 1'b1, 32'h2);
      rd("clr_hi", 32'h18, 1'b1, 32'h0);
      wr(32'h04, 32'h0, 4'hF);
      // W1C collision with a hardware set
      wr(32'h0C, 32'hFF, 4'hF);
      rd("stat_clr", 32'h0C, 1'b1, 32'h0);
      evt = 7'h04;
      wr(32'h0C, 32'h04, 4'hF);
      evt = 7'h00;
      rd("w1c_coll", 32'h0C, 1'b1, 32'h04);
      wr(32'h0C, 32'h04, 4'hE);
      rd("w1c_nolane", 32'h0C, 1'b1, 32'h04);
      wr(32'h0C, 32'h04, 4'hF);
      rd("w1c_clr", 32'h0C, 1'b1, 32'h0);
      // irq latency on mask set and mask clear
      evt = 7'h01;
      tick();
      evt = 7'h00;
      wr(32'h10, 32'h1, 4'hF);
      chk("irq_lag", {31'h0, irq}, 32'h0);
      tick();
      chk("irq_set", {31'h0, irq}, 32'h1);
      wr(32'h10, 32'h0, 4'hF);
      chk("irq_hold", {31'h0, irq}, 32'h1);
      tick();
      chk("irq_fall", {31'h0, irq}, 32'h0);
      // asynchronous reset mid-count with irq high
      wr(32'h10, 32'h1, 4'hF);
      wr(32'h04, 32'h1, 4'hF);
      tick();
      chk("irq_pre", {31'h0, irq}, 32'h1);
      @(negedge clk);
      sel = 4'hF; addr = 32'h00; wen = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rst_irq2", {31'h0, irq}, 32'h0);
      chk("rst_rack", {31'h0, rack}, 32'h0);
      chk("rst_rdat", rdat, 32'h0);
      tick();
      sel = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      rd("rst_lo", 32'h14, 1'b1, 32'h0);
      rd("rst_ctrl", 32'h04, 1'b1, 32'h0);
      rd("rst_mask", 32'h10, 1'b1, 32'h0);
      rd("rst_stat", 32'h0C, 1'b1, 32'h0);
      rd("rst_scr", 32'h08, 1'b1, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cmm_hst_regbank.md
# cmm_hst_regbank

Host-interface register bank that sits directly downstream of the APB-to-host bridge. It consumes the bridge's host request (sel/addr/wen/wdat) and returns address-hit and read data in the same cycle. It provides an ID register, control/scratch registers, a 64-bit event counter with atomic high-word snapshot, and a maskable W1C interrupt block driving a registered `irq`.

## Interface
- `C_AW`, 32: host address width.
- `C_BASE`, 32'h0000_0000: bank base address; bits [C_AW-1:8] are compared, bits [7:0] are the offset.
- `C_ID`, 32'h5654_0100: value returned by the ID register.
- `apb_pclk`  in  1  clock.
- `apb_preset`  in  1  reset; asynchronous, active-high.
- `hst_sel`  in  4  byte selects. Writes use the strobe; reads arrive as 4'hF; 0 means idle.
- `hst_addr`  in  C_AW  byte address.
- `hst_wen`  in  1  1 = write, 0 = read. Only meaningful when `hst_sel != 0`.
- `hst_wdat`  in  32  write data.
- `hst_rack`  out  1  combinational address hit.
- `hst_rdat`  out  32  combinational read data.
- `hw_evt`  in  7  hardware event pulses, one bit per event.
- `irq`  out  1  registered interrupt.

## Operation
- **Hit:** `hst_sel != 0` and `hst_addr[C_AW-1:8] == C_BASE[C_AW-1:8]` and `addr[1:0] == 0` and the offset is one of those listed below.
  - On a miss: `hst_rack = 0`, `hst_rdat = 0`, no state change.
- **Write:** `hst_wen & hit`. Each byte lane is updated only where `hst_sel[i] = 1`.
- **Read:** `!hst_wen & hit`. `hst_rdat` = register value. `hst_rdat` is 0 whenever there is no read hit.
- **Register map (offset, name, access):**
  - 0x00 ID, RO: returns `C_ID`.
  - 0x04 CTRL, RW, reset 0.
    - bit0 `cnt_en`.
    - bit1 `cnt_clr`: self-clearing, always reads 0.
    - bits[31:2] reserved, read 0.
  - 0x08 SCRATCH, RW, reset 0: all 32 bits, byte-strobed.
  - 0x0C INT_STAT, W1C, reset 0.
    - bits[6:0] are set by `hw_evt[6:0]`.
    - bit7 is set on counter low-word wrap.
    - Writing 1 clears a bit. Set wins over a simultaneous clear.
  - 0x10 INT_MASK, RW, reset 0: bits[7:0].
  - 0x14 CNT_LO, RO: live counter bits [31:0]. A read also captures counter bits [63:32] into the shadow register at the same clock edge.
  - 0x18 CNT_HI, RO: returns the shadow register, reset 0.
- **Counter (64-bit, reset 0):**
  - A write of `cnt_clr = 1` zeroes the counter at the next edge; clear has priority over increment.
  - Otherwise the counter increments by 1 each cycle while `cnt_en = 1`.
  - It wraps from all-ones to 0.
  - Low-word wrap (lo == 32'hFFFF_FFFF and incrementing) sets INT_STAT[7].
- **irq:** `irq <= |(INT_STAT & INT_MASK)` using the current register values.
  - Reset 0.
  - Lags a status or mask change by 1 cycle.

## Timing
- Reset values: `irq` = 0. All registers, the counter and the shadow are 0.
- `hst_rack` and `hst_rdat` are pure combinational functions of the inputs and register state.
- Read data must be valid in the same cycle as the request; the upstream bridge samples it at that edge.
- Writes take effect at the clock edge ending the request cycle. A read in the following cycle returns the new value.
- A CNT_LO read returns the pre-edge live value. The shadow captures the pre-edge hi word, so LO+HI forms a coherent 64-bit value.
- Simultaneous `hw_evt` pulse and W1C of the same bit: the bit stays 1.
- Simultaneous `cnt_clr` and a low-word wrap: counter goes to 0, INT_STAT[7] is not set.
- Reset asserted mid-operation clears everything asynchronously. No request is honoured while reset is high.

## Structure
- A shared package `cmm_hst_regbank_pkg` holds:
  - offset constants: `OFS_ID`, `OFS_CTRL`, `OFS_SCRATCH`, `OFS_INT_STAT`, `OFS_INT_MASK`, `OFS_CNT_LO`, `OFS_CNT_HI`;
  - CTRL bit indices;
  - `NUM_INT = 8`.
- One sub-module: `cmm_hst_w1c_reg`, a parameter-width W1C status register with hw-set, masked byte-strobed clear, and set-priority. It is used for INT_STAT.
- Decode, the RW registers, the counter and the shadow stay in the top level.

## Test plan
- **Reset and ID:** after reset, read 0x00 → `hst_rack = 1`, `hst_rdat = C_ID`; read 0x04, 0x08, 0x0C, 0x10, 0x18 → 0; `irq = 0`.
- **Byte strobes:**
  - Write 0x08 = 32'hAABB_CCDD with sel 4'b0101, then read → 32'h00BB_00DD.
  - Read of 0x1C, misaligned 0x09, or a `C_BASE` mismatch → `hst_rack = 0`, `hst_rdat = 0`.
- **Counter snapshot:**
  - Force the counter to hi = 1, lo = 32'hFFFF_FFFE with `cnt_en = 1`.
  - Reads of LO then HI return a coherent pair (HI = 1, not 2).
  - The wrap sets INT_STAT[7].
- **Counter clear:** write CTRL = 3 while counting → counter 0 next cycle; CTRL reads 1.
- **W1C collision:** pulse `hw_evt[2]` in the same cycle as a W1C of 0x04 to 0x0C → INT_STAT[2] = 1; a later W1C clears it to 0.
- **irq:**
  - INT_STAT[0] = 1, then write INT_MASK = 1 → `irq` = 1 one cycle later.
  - Mask 0 → `irq` falls one cycle later.
  - Assert reset mid-count → all outputs 0 immediately.
